// File: rtl/cambus_capture_ctrl.sv
// Frame capture controller: qualifies cambus pixels into linear frame-buffer writes
// with a valid/ready write port, double-buffer bank select and sticky error status.
module cambus_capture_ctrl #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [13:0]       vid_pixel_i,
  input  logic              vid_pixsync_i,
  input  logic              vid_hblank_i,
  input  logic              vid_vblank_i,
  input  logic              ctl_arm_i,
  input  logic              ctl_continuous_i,
  input  logic              ctl_abort_i,
  output logic              mem_wr_valid_o,
  input  logic              mem_wr_ready_i,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [13:0]       mem_wr_data_o,
  output logic              mem_wr_buf_o,
  output logic              sts_busy_o,
  output logic              sts_frame_done_o,
  output logic              sts_overflow_o,
  output logic              sts_geom_err_o,
  output logic [15:0]       sts_frame_count_o
);

  localparam int unsigned XCntW = $clog2(WIDTH + 1);
  localparam int unsigned YCntW = $clog2(HEIGHT + 1);
  localparam logic [XCntW-1:0] XEnd = XCntW'(WIDTH);
  localparam logic [YCntW-1:0] YEnd = YCntW'(HEIGHT);

  typedef enum logic [2:0] {StIdle, StSync, StArmed, StCapture, StDone} state_e;

  state_e             state_q, state_d;
  logic [XCntW-1:0]   x_q, x_d;
  logic [YCntW-1:0]   y_q, y_d;
  logic               line_act_q, line_act_d;
  logic               fend_q, fend_d;
  logic               geom_q, geom_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               buf_q, buf_d;
  logic               wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [13:0]        wr_data_q, wr_data_d;

  logic pix_cap;
  logic store;
  logic line_end;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    line_act_d = line_act_q;
    fend_d     = fend_q;
    geom_d     = geom_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    store      = 1'b0;
    line_end   = 1'b0;

    // The pixsync that moves ARMED to CAPTURE is already part of the frame.
    pix_cap = vid_pixsync_i && !vid_vblank_i &&
              ((state_q == StCapture && !fend_q) || state_q == StArmed);

    unique case (state_q)
      StIdle: begin
        if (ctl_arm_i) begin
          state_d    = StSync;
          geom_d     = 1'b0;
          ovf_d      = 1'b0;
          x_d        = '0;
          y_d        = '0;
          line_act_d = 1'b0;
          fend_d     = 1'b0;
        end
      end
      StSync: begin
        if (vid_pixsync_i && vid_vblank_i) state_d = StArmed;
      end
      StArmed: begin
        if (pix_cap) state_d = StCapture;
      end
      StCapture: begin
        if (vid_pixsync_i && vid_vblank_i && !fend_q) begin
          fend_d = 1'b1;
          if (x_q != '0) line_end = 1'b1;
        end
      end
      StDone: begin
        state_d    = ctl_continuous_i ? StArmed : StIdle;
        cnt_d      = cnt_q + 16'd1;
        buf_d      = !buf_q;
        x_d        = '0;
        y_d        = '0;
        line_act_d = 1'b0;
        fend_d     = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (pix_cap) begin
      if (!vid_hblank_i) begin
        line_act_d = 1'b1;
        if (x_q < XEnd && y_q < YEnd) begin
          store = 1'b1;
          x_d   = x_q + 1'b1;
        end
      end else if (line_act_q) begin
        line_end = 1'b1;
      end
    end

    if (line_end) begin
      if (x_q != XEnd && y_q < YEnd) geom_d = 1'b1;
      x_d        = '0;
      line_act_d = 1'b0;
      if (y_q < YEnd) y_d = y_q + 1'b1;
    end

    // Frame end waits in CAPTURE until the last write has drained.
    if (state_q == StCapture && fend_d && !wr_valid_q) begin
      state_d = StDone;
      if (y_d != YEnd) geom_d = 1'b1;
    end

    if (wr_valid_q && mem_wr_ready_i) wr_valid_d = 1'b0;
    if (store) begin
      if (wr_valid_q && !mem_wr_ready_i) begin
        ovf_d = 1'b1;
      end else begin
        wr_valid_d = 1'b1;
        wr_addr_d  = ADDR_W'(y_q) * ADDR_W'(WIDTH) + ADDR_W'(x_q);
        wr_data_d  = vid_pixel_i;
      end
    end

    // Abort overrides everything except draining an already pending write.
    if (ctl_abort_i) begin
      state_d    = StIdle;
      x_d        = '0;
      y_d        = '0;
      line_act_d = 1'b0;
      fend_d     = 1'b0;
      geom_d     = geom_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      wr_valid_d = wr_valid_q && !mem_wr_ready_i;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      line_act_q <= 1'b0;
      fend_q     <= 1'b0;
      geom_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      buf_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      line_act_q <= line_act_d;
      fend_q     <= fend_d;
      geom_q     <= geom_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign mem_wr_valid_o    = wr_valid_q;
  assign mem_wr_addr_o     = wr_addr_q;
  assign mem_wr_data_o     = wr_data_q;
  assign mem_wr_buf_o      = buf_q;
  assign sts_busy_o        = (state_q != StIdle);
  assign sts_frame_done_o  = (state_q == StDone);
  assign sts_overflow_o    = ovf_q;
  assign sts_geom_err_o    = geom_q;
  assign sts_frame_count_o = cnt_q;

endmodule

// File: tb/tb_cambus_capture_ctrl.sv
// Scoreboard bench for cambus_capture_ctrl on a 4x2 frame: expected writes are queued
// by the stimulus and checked by an independent monitor at the falling clock edge.
module tb_cambus_capture_ctrl;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [13:0]   vid_pixel;
  logic          vid_pixsync, vid_hblank, vid_vblank;
  logic          ctl_arm, ctl_continuous, ctl_abort;
  logic          mem_wr_valid, mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [13:0]   mem_wr_data;
  logic          mem_wr_buf;
  logic          sts_busy, sts_frame_done, sts_overflow, sts_geom_err;
  logic [15:0]   sts_frame_count;

  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;
  logic [AW+13:0] exp_q[$];

  cambus_capture_ctrl #(
    .WIDTH (4),
    .HEIGHT(2),
    .ADDR_W(AW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .vid_pixel_i      (vid_pixel),
    .vid_pixsync_i    (vid_pixsync),
    .vid_hblank_i     (vid_hblank),
    .vid_vblank_i     (vid_vblank),
    .ctl_arm_i        (ctl_arm),
    .ctl_continuous_i (ctl_continuous),
    .ctl_abort_i      (ctl_abort),
    .mem_wr_valid_o   (mem_wr_valid),
    .mem_wr_ready_i   (mem_wr_ready),
    .mem_wr_addr_o    (mem_wr_addr),
    .mem_wr_data_o    (mem_wr_data),
    .mem_wr_buf_o     (mem_wr_buf),
    .sts_busy_o       (sts_busy),
    .sts_frame_done_o (sts_frame_done),
    .sts_overflow_o   (sts_overflow),
    .sts_geom_err_o   (sts_geom_err),
    .sts_frame_count_o(sts_frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input logic h, input logic v, input logic [13:0] d);
    vid_pixsync = 1'b1;
    vid_hblank  = h;
    vid_vblank  = v;
    vid_pixel   = d;
    tick();
    vid_pixsync = 1'b0;
    vid_hblank  = 1'b0;
    vid_vblank  = 1'b0;
    tick();
  endtask

  task automatic arm();
    ctl_arm = 1'b1;
    tick();
    ctl_arm = 1'b0;
  endtask

  task automatic abort();
    ctl_abort = 1'b1;
    tick();
    ctl_abort = 1'b0;
  endtask

  // Two lines; the second one carries len1 active pixels.
  task automatic send_frame(input int len1);
    logic [13:0] d;
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < ((l == 1) ? len1 : 4); p++) begin
        d = 14'(32'h100 + l * 16 + p);
        exp_q.push_back({AW'(l * 4 + p), d});
        pix(1'b0, 1'b0, d);
      end
      pix(1'b1, 1'b0, 14'h0);
    end
  endtask

  // Monitor: accepted writes against the scoreboard, stall stability, frame_done pulses.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [13:0]   prev_data;
  initial begin
    logic [AW+13:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_wr_valid && mem_wr_ready) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL write_unexpected: got addr %0d data %h, none queued",
                     mem_wr_addr, mem_wr_data);
          end else begin
            e = exp_q.pop_front();
            if ({mem_wr_addr, mem_wr_data} !== e) begin
              n_fail++;
              $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                       mem_wr_addr, mem_wr_data, e[AW+13:14], e[13:0]);
            end
          end
        end
        if (prev_stall) begin
          n_chk++;
          if (mem_wr_valid !== 1'b1 || mem_wr_addr !== prev_addr || mem_wr_data !== prev_data) begin
            n_fail++;
            $display("FAIL stall_hold: got v%0b a%0d d%h expected v1 a%0d d%h",
                     mem_wr_valid, mem_wr_addr, mem_wr_data, prev_addr, prev_data);
          end
        end
        if (sts_frame_done) done_seen++;
      end
      prev_stall = rst_n && mem_wr_valid && !mem_wr_ready;
      prev_addr  = mem_wr_addr;
      prev_data  = mem_wr_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; vid_pixel = '0; vid_pixsync = 1'b0; vid_hblank = 1'b0; vid_vblank = 1'b0;
    ctl_arm = 1'b0; ctl_continuous = 1'b0; ctl_abort = 1'b0; mem_wr_ready = 1'b1;
    idle(3);
    check("rst_valid", 32'(mem_wr_valid), 0);
    check("rst_addr", 32'(mem_wr_addr), 0);
    check("rst_data", 32'(mem_wr_data), 0);
    check("rst_buf", 32'(mem_wr_buf), 0);
    check("rst_busy", 32'(sts_busy), 0);
    check("rst_done", 32'(sts_frame_done), 0);
    check("rst_flags", 32'({sts_overflow, sts_geom_err}), 0);
    check("rst_count", 32'(sts_frame_count), 0);
    rst_n = 1'b1;
    tick();

    // Full clean frame.
    arm();
    check("armed_busy", 32'(sts_busy), 1);
    pix(1'b0, 1'b1, 14'h0);
    send_frame(4);
    pix(1'b0, 1'b1, 14'h0);
    idle(3);
    check("f1_done", 32'(done_seen), 1);
    check("f1_count", 32'(sts_frame_count), 1);
    check("f1_buf", 32'(mem_wr_buf), 1);
    check("f1_geom", 32'(sts_geom_err), 0);
    check("f1_ovf", 32'(sts_overflow), 0);
    check("f1_idle", 32'(sts_busy), 0);
    check("f1_queue", 32'(exp_q.size()), 0);

    // Short second line.
    arm();
    pix(1'b0, 1'b1, 14'h0);
    send_frame(3);
    pix(1'b0, 1'b1, 14'h0);
    idle(3);
    check("short_geom", 32'(sts_geom_err), 1);
    check("short_done", 32'(done_seen), 2);
    check("short_count", 32'(sts_frame_count), 2);
    check("short_buf", 32'(mem_wr_buf), 0);
    check("short_queue", 32'(exp_q.size()), 0);

    // Back-pressure across two pixels: first held, second dropped.
    arm();
    check("arm_clears_geom", 32'(sts_geom_err), 0);
    pix(1'b0, 1'b1, 14'h0);
    mem_wr_ready = 1'b0;
    exp_q.push_back({AW'(0), 14'h2a0});
    pix(1'b0, 1'b0, 14'h2a0);
    pix(1'b0, 1'b0, 14'h2a1);
    check("ovf_set", 32'(sts_overflow), 1);
    check("stall_valid", 32'(mem_wr_valid), 1);
    check("stall_addr", 32'(mem_wr_addr), 0);
    check("stall_data", 32'(mem_wr_data), 32'h2a0);
    idle(2);
    mem_wr_ready = 1'b1;
    for (int p = 2; p < 4; p++) begin
      exp_q.push_back({AW'(p), 14'(32'h2a0 + p)});
      pix(1'b0, 1'b0, 14'(32'h2a0 + p));
    end
    pix(1'b1, 1'b0, 14'h0);
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back({AW'(4 + p), 14'(32'h2b0 + p)});
      pix(1'b0, 1'b0, 14'(32'h2b0 + p));
    end
    pix(1'b1, 1'b0, 14'h0);
    pix(1'b0, 1'b1, 14'h0);
    idle(3);
    check("ovf_sticky", 32'(sts_overflow), 1);
    check("ovf_geom", 32'(sts_geom_err), 0);
    check("ovf_count", 32'(sts_frame_count), 3);
    check("ovf_queue", 32'(exp_q.size()), 0);

    // Continuous mode from a fresh reset.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    tick();
    ctl_continuous = 1'b1;
    arm();
    pix(1'b0, 1'b1, 14'h0);
    for (int f = 0; f < 3; f++) begin
      send_frame(4);
      pix(1'b0, 1'b1, 14'h0);
      check("cont_count", 32'(sts_frame_count), 32'(f + 1));
      check("cont_buf", 32'(mem_wr_buf), (f % 2 == 0) ? 1 : 0);
      check("cont_busy", 32'(sts_busy), 1);
    end
    check("cont_done", 32'(done_seen), 6);
    ctl_continuous = 1'b0;

    // Abort from ARMED, simultaneous arm+abort, then abort mid-frame.
    abort();
    check("abort_idle", 32'(sts_busy), 0);
    ctl_arm = 1'b1;
    ctl_abort = 1'b1;
    tick();
    ctl_arm = 1'b0;
    ctl_abort = 1'b0;
    check("arm_abort_idle", 32'(sts_busy), 0);
    arm();
    pix(1'b0, 1'b1, 14'h0);
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back({AW'(p), 14'(32'h300 + p)});
      pix(1'b0, 1'b0, 14'(32'h300 + p));
    end
    pix(1'b1, 1'b0, 14'h0);
    exp_q.push_back({AW'(4), 14'h310});
    pix(1'b0, 1'b0, 14'h310);
    abort();
    check("abort_mid_idle", 32'(sts_busy), 0);
    idle(3);
    check("abort_no_done", 32'(done_seen), 6);
    check("abort_count", 32'(sts_frame_count), 3);
    check("abort_buf", 32'(mem_wr_buf), 1);
    arm();
    pix(1'b0, 1'b1, 14'h0);
    send_frame(4);
    pix(1'b0, 1'b1, 14'h0);
    idle(3);
    check("rearm_count", 32'(sts_frame_count), 4);
    check("rearm_queue", 32'(exp_q.size()), 0);

    // Reset while a write is stalled.
    arm();
    pix(1'b0, 1'b1, 14'h0);
    mem_wr_ready = 1'b0;
    pix(1'b0, 1'b0, 14'h123);
    check("prerst_valid", 32'(mem_wr_valid), 1);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(mem_wr_valid), 0);
    check("midrst_addr", 32'(mem_wr_addr), 0);
    check("midrst_data", 32'(mem_wr_data), 0);
    check("midrst_buf", 32'(mem_wr_buf), 0);
    check("midrst_busy", 32'(sts_busy), 0);
    check("midrst_count", 32'(sts_frame_count), 0);
    check("midrst_flags", 32'({sts_overflow, sts_geom_err, sts_frame_done}), 0);
    rst_n = 1'b1;
    mem_wr_ready = 1'b1;
    idle(2);
    check("postrst_valid", 32'(mem_wr_valid), 0);
    check("postrst_busy", 32'(sts_busy), 0);
    check("final_queue", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
